// File: rtl/pdm_multichannel_cic.sv
// Multi-line PDM capture: mic clock, 2-flop sync, per-channel CIC decimation,
// one-frame holding buffer with drop-on-backpressure and status counters.
module pdm_multichannel_cic #(
    parameter int CLK_FREQ          = 100_000_000,
    parameter int PDM_CLK_FREQ      = 2_000_000,
    parameter int NUM_LINES         = 1,
    parameter int CIC_STAGES        = 4,
    parameter int DECIMATION_FACTOR = 64,
    parameter int OUT_WIDTH         = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 clr_status,
    output logic                                 M_CLK,
    input  logic [NUM_LINES-1:0]                 M_DATA,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUT_WIDTH-1:0]                 out_data,
    output logic [$clog2(2*NUM_LINES)-1:0]       out_channel,
    output logic                                 out_last,
    output logic                                 overflow,
    output logic [15:0]                          drop_count
);

    localparam int HALF = CLK_FREQ / (2 * PDM_CLK_FREQ);
    localparam int C    = 2 * NUM_LINES;
    localparam int CW   = $clog2(C);
    localparam int LOGR = $clog2(DECIMATION_FACTOR);
    localparam int W    = 2 + CIC_STAGES * LOGR;
    localparam int SH   = (W >= OUT_WIDTH) ? (W - OUT_WIDTH) : 0;
    localparam int DW   = $clog2(HALF);
    localparam int SW   = $clog2(CIC_STAGES + 1);

    logic [DW-1:0]        div_cnt;
    logic                 tc;
    logic                 samp_even;
    logic                 samp_odd;
    logic [NUM_LINES-1:0] sync1;
    logic [NUM_LINES-1:0] sync2;
    logic [LOGR-1:0]      dec_cnt;
    logic                 dec_pend;
    logic [SW-1:0]        settle_cnt;
    logic                 settled;
    logic                 commit;

    logic [OUT_WIDTH-1:0] pcm  [C];
    logic [OUT_WIDTH-1:0] hbuf [C];
    logic                 busy;
    logic [CW-1:0]        rd_idx;
    logic                 last_sel;
    logic                 hs;
    logic                 free_now;
    logic                 drop;

    assign tc        = (div_cnt == DW'(HALF - 1));
    assign samp_even = en && tc && M_CLK;
    assign samp_odd  = en && tc && !M_CLK;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            M_CLK   <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            M_CLK   <= ~M_CLK;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= M_DATA;
            sync2 <= sync1;
        end
    end

    // All lines share the divider, so one odd-sample counter serves every line.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            dec_cnt    <= '0;
            dec_pend   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            dec_pend <= samp_odd && (&dec_cnt);
            if (samp_odd)
                dec_cnt <= dec_cnt + 1'b1;
            if (dec_pend && !settled)
                settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign settled = (settle_cnt == SW'(CIC_STAGES));
    assign commit  = dec_pend && settled;

    for (genvar g = 0; g < C; g++) begin : g_ch
        logic signed [W-1:0] x;
        logic signed [W-1:0] integ     [CIC_STAGES];
        logic signed [W-1:0] integ_nxt [CIC_STAGES];
        logic signed [W-1:0] cd        [CIC_STAGES];
        logic signed [W-1:0] comb_v    [CIC_STAGES];
        logic signed [W-1:0] y;
        logic                strobe;

        assign strobe = (g % 2 == 1) ? samp_odd : samp_even;

        always_comb begin
            x = sync2[g/2] ? W'(1) : {W{1'b1}};
            integ_nxt[0] = integ[0] + x;
            for (int s = 1; s < CIC_STAGES; s++)
                integ_nxt[s] = integ[s] + integ_nxt[s-1];
            comb_v[0] = integ[CIC_STAGES-1] - cd[0];
            for (int s = 1; s < CIC_STAGES; s++)
                comb_v[s] = comb_v[s-1] - cd[s];
        end

        // Combs run one cycle after the last odd sample, on settled integrators.
        always_ff @(posedge clk) begin
            if (rst || !en) begin
                for (int s = 0; s < CIC_STAGES; s++) begin
                    integ[s] <= '0;
                    cd[s]    <= '0;
                end
            end else begin
                if (strobe)
                    for (int s = 0; s < CIC_STAGES; s++)
                        integ[s] <= integ_nxt[s];
                if (dec_pend) begin
                    cd[0] <= integ[CIC_STAGES-1];
                    for (int s = 1; s < CIC_STAGES; s++)
                        cd[s] <= comb_v[s-1];
                end
            end
        end

        assign y      = comb_v[CIC_STAGES-1];
        assign pcm[g] = OUT_WIDTH'(y >>> SH);
    end

    assign last_sel = (rd_idx == CW'(C - 1));
    assign hs       = busy && out_ready;
    assign free_now = !busy || (hs && last_sel);
    assign drop     = commit && !free_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            rd_idx <= '0;
            for (int c = 0; c < C; c++)
                hbuf[c] <= '0;
        end else if (commit && free_now) begin
            busy   <= 1'b1;
            rd_idx <= '0;
            for (int c = 0; c < C; c++)
                hbuf[c] <= pcm[c];
        end else if (hs) begin
            if (last_sel) begin
                busy   <= 1'b0;
                rd_idx <= '0;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_status)
                drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end else if (clr_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    assign out_valid   = busy;
    assign out_data    = hbuf[rd_idx];
    assign out_channel = rd_idx;
    assign out_last    = busy && last_sel;

endmodule

// File: tb/tb_pdm_multichannel_cic.sv
// Scoreboard bench for pdm_multichannel_cic with four lines, each line
// carrying a different PDM pattern so every frame has a known result.
module tb_pdm_multichannel_cic;

    localparam int NL    = 4;
    localparam int C     = 8;
    localparam int CW    = 3;
    localparam int FRAME = 3200;
    localparam int HALF  = 25;
    localparam logic [15:0] EXP [C] = '{
        16'h4000, 16'h4000, 16'h4000, 16'hC000,
        16'h0000, 16'h0000, 16'hC000, 16'hC000
    };

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [15:0]   data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr_status;
    logic          M_CLK;
    logic [NL-1:0] M_DATA;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [CW-1:0] out_channel;
    logic          out_last;
    logic          overflow;
    logic [15:0]   drop_count;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   n_valid = 0;
    int   ch0_cyc [$];
    exp_t sb [$];
    logic alt = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge M_CLK) alt <= ~alt;

    // line0 all ones, line1 follows M_CLK, line2 flips every period, line3 zeros
    assign M_DATA = {1'b0, alt, M_CLK, 1'b1};

    pdm_multichannel_cic #(
        .CLK_FREQ(100_000_000),
        .PDM_CLK_FREQ(2_000_000),
        .NUM_LINES(NL),
        .CIC_STAGES(4),
        .DECIMATION_FACTOR(64),
        .OUT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .clr_status(clr_status),
        .M_CLK(M_CLK),
        .M_DATA(M_DATA),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_channel(out_channel),
        .out_last(out_last),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame();
        exp_t e;
        for (int c = 0; c < C; c++) begin
            e.ch   = CW'(c);
            e.data = EXP[c];
            e.last = (c == C - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1) begin
            n_valid++;
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("out_channel", out_channel, e.ch);
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    if (out_channel == 0)
                        ch0_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        int t_en;
        int L;
        int v0;
        logic [15:0] d0;
        logic [CW-1:0] c0;

        rst = 1'b1; en = 1'b0; clr_status = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_mclk", M_CLK, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_status", {overflow, drop_count}, 0);

        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (M_CLK !== 1'b0) bad++;
        end
        chk("mclk_idle", bad, 0);

        en = 1'b1;
        t_en = cyc;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (M_CLK !== 1'b1 && n < 200);
        chk("mclk_first_rise", n, HALF);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (M_CLK === 1'b1 && n < 200);
        chk("mclk_high", n, HALF);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (M_CLK !== 1'b1 && n < 200);
        chk("mclk_low", n, HALF);

        out_ready = 1'b1;
        push_frame();
        push_frame();
        push_frame();
        while (cyc < t_en + 4 * FRAME + 2000) begin @(posedge clk); #1; end
        chk("settle_quiet", n_valid, 0);
        wait_drain("drain_stream", 3 * FRAME + 2000);
        if (ch0_cyc.size() >= 2)
            chk("frame_gap", ch0_cyc[$] - ch0_cyc[$-1], FRAME);
        else
            chk("frame_gap_count", ch0_cyc.size(), 2);

        out_ready = 1'b0;
        push_frame();
        n = 0;
        while (out_valid !== 1'b1 && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
        chk("bp_valid", out_valid, 1);
        L  = cyc;
        d0 = out_data;
        c0 = out_channel;
        bad = 0;
        repeat (3 * FRAME + 100) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== d0 || out_channel !== c0) bad++;
        end
        chk("hold_stable", bad, 0);
        chk("hold_channel", c0, 0);
        chk("hold_data", d0, 16'h4000);
        chk("bp_overflow", overflow, 1);
        chk("bp_drop_count", drop_count, 3);

        while (cyc < L + 4 * FRAME - 1) begin @(posedge clk); #1; end
        clr_status = 1'b1;
        @(posedge clk);
        #1;
        clr_status = 1'b0;
        chk("clr_drop_overflow", overflow, 1);
        chk("clr_drop_count", drop_count, 1);

        out_ready = 1'b1;
        wait_drain("bp_drain", 100);
        clr_status = 1'b1;
        @(posedge clk);
        #1;
        clr_status = 1'b0;
        chk("clr_overflow", overflow, 0);
        chk("clr_count", drop_count, 0);

        push_frame();
        wait_drain("post_clr_frame", FRAME + 500);

        push_frame();
        n = 0;
        while (sb.size() > 5 && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_mclk", M_CLK, 0);
        chk("rst_mid_channel", out_channel, 0);
        sb.delete();
        rst = 1'b0;
        t_en = cyc;
        v0 = n_valid;
        while (cyc < t_en + 4 * FRAME + 2000) begin @(posedge clk); #1; end
        chk("resettle_quiet", n_valid - v0, 0);
        push_frame();
        wait_drain("resettle_frame", FRAME);

        chk("sb_final", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_multichannel_cic.md
Name: pdm_multichannel_cic

Overview:
Next-generation PDM capture front end. It generates the microphone clock and captures up to 4 shared PDM data lines, each carrying two microphones: one sampled on the high phase, one on the low phase. Each channel runs a per-channel CIC decimator. Channel-interleaved PCM frames are emitted on a valid/ready stream, with drop-on-backpressure and status counters. It sits between the mic pins and the downstream FIR/compression/FIFO chain.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- PDM_CLK_FREQ, 2_000_000, target mic clock. HALF = CLK_FREQ/(2*PDM_CLK_FREQ), truncated; HALF must be at least 3.
- NUM_LINES, 1, number of PDM data lines (1..4). Channel count C = 2*NUM_LINES.
- CIC_STAGES, 4, CIC order N (1..6).
- DECIMATION_FACTOR, 64, R, a power of two between 8 and 512.
- OUT_WIDTH, 16, PCM sample width.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, capture enable.
- clr_status, in, 1, one-cycle pulse that clears overflow and drop_count.
- M_CLK, out, 1, microphone clock.
- M_DATA, in, NUM_LINES, PDM data lines; asynchronous to clk.
- out_valid, out, 1, sample valid.
- out_ready, in, 1, downstream ready.
- out_data, out, OUT_WIDTH, signed PCM sample.
- out_channel, out, max(1,clog2(C)), channel index of out_data.
- out_last, out, 1, marks the last channel (C-1) of a frame.
- overflow, out, 1, sticky frame-drop flag.
- drop_count, out, 16, number of dropped frames; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0, M_CLK=0. Divider, CIC state, settle counter and holding buffer are cleared. rst takes priority over every other input.
- Clock divider: counter runs 0..HALF-1. At the terminal count M_CLK toggles and the counter wraps. M_CLK is high for HALF cycles and low for HALF cycles. First rising edge occurs HALF cycles after en rises.
- en=0: M_CLK is forced to 0 and the divider, CIC integrators/combs and settle counter are cleared. A frame already in the holding buffer still drains. Re-enabling restarts the full settle sequence.
- Input sync: each M_DATA bit passes through a 2-flop synchroniser.
- Sample points (synchronised value):
  - Channel 2k (line k) is taken in the terminal-count cycle while M_CLK=1.
  - Channel 2k+1 is taken in the terminal-count cycle while M_CLK=0.
- Mapping: bit 1 maps to +1, bit 0 maps to -1.
- CIC width and arithmetic: internal width W = 2 + N*log2(R). Two's complement, wrap-around arithmetic in the integrators is intended.
- CIC integrators: update once per sample of their own channel.
- CIC combs and decimation:
  - A per-line decimation counter counts odd-channel samples. Because the odd channel is sampled in the second half of each period, both channels of a line complete together.
  - Every R-th odd sample, the comb chain runs for both channels of the line. Combs may be pipelined but must finish before the frame is committed.
- Output scaling: the comb result is truncated to its top OUT_WIDTH bits; if W < OUT_WIDTH it is sign-extended instead. With defaults (W=26), full-scale all-ones gives +16384 (0x4000) and all-zeros gives -16384 (0xC000).
- Frame commit: one decimation event per R PDM periods commits all C channel results together.
- Settling: the first CIC_STAGES frames after reset or after en rises are discarded. They are not counted as drops.
- Holding buffer: one frame of C samples.
  - If the buffer is empty at commit, the frame loads and streaming starts the next cycle.
  - If the buffer is still draining at commit, the new frame is dropped: overflow is set, drop_count increments (saturating) and the buffer contents are untouched.
- Stream handshake: samples are emitted in channel order 0..C-1.
  - out_valid stays high and out_data, out_channel and out_last stay stable until the cycle where out_valid && out_ready.
  - out_last=1 only for channel C-1.
  - The buffer becomes free in the cycle the last sample is accepted. A commit in that same cycle loads normally; it is not a drop.
- Status clear: clr_status clears overflow and drop_count. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.

Test Plan:
- Reset release, en=1, CLK_FREQ=100M, PDM_CLK_FREQ=2M: M_CLK toggles every 25 cycles, giving a 50-cycle period. M_CLK stays 0 whenever en=0.
- NUM_LINES=1, all lines held high, out_ready=1, defaults: no output for the first 4 frames, then every frame is ch0=0x4000, ch1=0x4000, with out_last set on ch1. Frame spacing is 64*50 cycles.
- Line driven 1 in the high phase and 0 in the low phase: settled output is ch0=+16384, ch1=-16384. An alternating 1,0 pattern per channel settles to 0.
- NUM_LINES=4, out_ready=0 for 3 frame periods after the first valid frame: held sample stays stable with out_channel=0, overflow=1, drop_count=3. Releasing out_ready drains the original frame, channels 0..7.
- clr_status pulse with no drop: overflow=0 and drop_count=0 next cycle. clr_status coincident with a drop: overflow=1 and drop_count=1.
- rst asserted mid-frame while out_valid=1: next cycle out_valid=0 and M_CLK=0. After release the 4-frame settle repeats before any output.
